// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states and bit-timing constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    localparam logic [3:0]  START_SAMPLE_TICK = 4'd7;
    localparam logic [3:0]  BIT_LAST_TICK     = 4'd15;
    localparam int unsigned DATA_BITS         = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous pad input; resets to 1 (idle line).
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw input one stage further along the chain each clock.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
    end

    // Chain registers; reset to all ones so the line reads idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= sync_d;
    end

    assign o_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_bit.sv
// UART receive bit engine: 16x oversampled 8N1 deframer writing good bytes to the RX FIFO.
// Optional parity bit (and o_parity_err port) enabled by defining UART_RX_PARITY_EN.
module uart_rx_bit
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_16x_baud_en,
    input  logic       i_uart_rx_ser,
    input  logic       i_fifo_full,
    output logic [7:0] ov_fifo_din,
    output logic       o_fifo_wr,
    output logic       o_frame_err,
    output logic       o_overflow,
    output logic       o_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       o_parity_err
`endif
);

    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("PARITY_ODD must be 0 or 1");
    end

    logic rx_s;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (i_uart_rx_ser),
        .o_sync  (rx_s)
    );

    rx_state_e  state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] dout_q, dout_d;
    logic       armed_q, armed_d;
    logic       wr_q, wr_d;
    logic       ferr_q, ferr_d;
    logic       ovf_q, ovf_d;
`ifdef UART_RX_PARITY_EN
    logic       par_q, par_d;
    logic       perr_q, perr_d;
    logic       par_bad;
    assign par_bad = par_q != (^shift_q ^ 1'(PARITY_ODD));
`endif

    // Next-state, counter and registered-output computation; all progress gated by the baud enable.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        armed_d = armed_q;
        wr_d    = 1'b0;
        ferr_d  = 1'b0;
        ovf_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (i_16x_baud_en) begin
            tick_d = tick_q + 4'd1;
            case (state_q)
                IDLE: begin
                    tick_d = '0;
                    // A line still low after reset/break must go high before a start edge counts.
                    if (!armed_q) begin
                        if (rx_s) armed_d = 1'b1;
                    end else if (!rx_s) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (tick_q == START_SAMPLE_TICK) begin
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end
                    end
                end
                DATA: begin
                    if (tick_q == BIT_LAST_TICK) begin
                        shift_d = {rx_s, shift_q[7:1]};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_q == BIT_LAST_TICK) begin
                        par_d   = rx_s;
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick_q == BIT_LAST_TICK) begin
                        if (!rx_s) begin
                            ferr_d  = 1'b1;
                            armed_d = 1'b0;
                            state_d = BREAK;
                        end else begin
                            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                perr_d = 1'b1;
                            end else
`endif
                            if (i_fifo_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                wr_d   = 1'b1;
                                dout_d = shift_q;
                            end
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        armed_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            armed_q <= 1'b0;
            wr_q    <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            armed_q <= armed_d;
            wr_q    <= wr_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign ov_fifo_din = dout_q;
    assign o_fifo_wr   = wr_q;
    assign o_frame_err = ferr_q;
    assign o_overflow  = ovf_q;
    assign o_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_bit.sv
// Scoreboard bench for uart_rx_bit: frames are serialised onto the line, the expected
// FIFO/error event for each is queued, and a monitor matches every DUT pulse.
`timescale 1ns/1ps
module tb_uart_rx_bit;

    localparam int BIT_CLKS   = 64;   // 16 enables per bit, one enable every 4 clocks
    localparam int PARITY_ODD = 0;

    // event kinds in the scoreboard
    localparam logic [1:0] K_WR = 2'd0, K_FERR = 2'd1, K_OVF = 2'd2, K_PERR = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       rx = 1'b1;
    logic       full = 1'b0;
    logic [7:0] dout;
    logic       wr, ferr, ovf, busy;
    logic       perr;

    int tests = 0;
    int fails = 0;
    logic [9:0] exp_q[$];
    logic [7:0] last_wr = 8'h00;
    logic       prev_pulse = 1'b0;

    uart_rx_bit #(.SYNC_STAGES(2), .PARITY_ODD(PARITY_ODD)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_16x_baud_en(en),
        .i_uart_rx_ser(rx),
        .i_fifo_full  (full),
        .ov_fifo_din  (dout),
        .o_fifo_wr    (wr),
        .o_frame_err  (ferr),
        .o_overflow   (ovf),
        .o_busy       (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .o_parity_err (perr)
`endif
    );
`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 en = 1'b1;
            @(posedge clk);
            #1 en = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every pulse must match the oldest queued expectation
    int n_pulse;
    logic [1:0] act_kind;
    logic [9:0] e;
    always @(negedge clk) begin
        if (reset) begin
            prev_pulse = 1'b0;
        end else begin
            n_pulse = int'(wr) + int'(ferr) + int'(ovf) + int'(perr);
            if (n_pulse != 0) begin
                check("pulse_onehot", n_pulse, 1);
                check("pulse_width", {31'd0, prev_pulse}, 0);
                act_kind = wr ? K_WR : ferr ? K_FERR : ovf ? K_OVF : K_PERR;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got kind %0d data %0h expected none", act_kind, dout);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", act_kind, e[9:8]);
                    if (e[9:8] == K_WR) begin
                        check("fifo_din", dout, e[7:0]);
                        last_wr = e[7:0];
                    end else begin
                        check("din_hold", dout, last_wr);
                    end
                end
            end
            prev_pulse = (n_pulse != 0);
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int nb);
        for (int i = 0; i < nb; i++) send_bit(1'b1);
    endtask

    // expected outcome from frame rules: low stop -> framing error; bad parity -> parity error;
    // full FIFO -> overflow; otherwise the byte is written
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic full_v,
                              input logic par_ok);
        logic [1:0] k;
        if (!stop_bit)    k = K_FERR;
        else if (!par_ok) k = K_PERR;
        else if (full_v)  k = K_OVF;
        else              k = K_WR;
        exp_q.push_back({k, d});
        full = full_v;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ PARITY_ODD[0] ^ ~par_ok);
`endif
        send_bit(stop_bit);
    endtask

    task automatic release_on_enable();
        @(posedge clk);
        while (en !== 1'b1) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_pulses"}, {wr, ferr, ovf, perr}, 0);
        check({name, "_din"}, dout, 0);
    endtask

    initial begin
        logic [7:0] c3;
        logic [7:0] d;
        logic       stop_b, full_b;
        c3 = 8'hC3;

        // reset state
        repeat (5) @(posedge clk);
        #1;
        check_quiet("reset");
        release_on_enable();
        idle_bits(2);

        // single byte
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        idle_bits(1);

        // back-to-back, no idle gap
        send_frame(8'h00, 1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        send_frame(8'h55, 1'b1, 1'b0, 1'b1);
        idle_bits(1);

        // short low glitch: START entered then abandoned, no pulse
        rx = 1'b0;
        repeat (12) @(posedge clk);
        #1 check("glitch_busy", busy, 1);
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1 check("glitch_idle", busy, 0);

        // low stop bit then a held-low line: one framing error only
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (40 * BIT_CLKS) @(posedge clk);
        #1 check("break_busy", busy, 1);
        idle_bits(2);
        check("break_exit", busy, 0);

        // overflow then a normal write
        send_frame(8'h81, 1'b1, 1'b1, 1'b1);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b1);
        idle_bits(1);

        // reset in the middle of data bit 4 of 0xC3 (a low bit)
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(c3[i]);
        rx = c3[4];
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1 reset = 1'b1;
        last_wr = 8'h00;
        repeat (5) @(posedge clk);
        #1 check_quiet("midreset");
        release_on_enable();
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1 check("low_after_reset_busy", busy, 0);
        idle_bits(2);
        send_frame(8'h12, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
`ifdef UART_RX_PARITY_EN
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        idle_bits(1);
`endif

        // randomized frames
        for (int f = 0; f < 20; f++) begin
            d      = 8'($urandom);
            stop_b = ($urandom_range(0, 7) != 0);
            full_b = ($urandom_range(0, 3) == 0);
            send_frame(d, stop_b, full_b, 1'b1);
            if (!stop_b) begin
                rx = 1'b0;
                repeat ($urandom_range(0, 3) * BIT_CLKS) @(posedge clk);
                #1 idle_bits(1);
            end
            idle_bits($urandom_range(0, 2));
        end
        full = 1'b0;

        idle_bits(4);
        check("queue_empty", exp_q.size(), 0);
        check("final_idle", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
